// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, LOCK)
//   DEFAULT_DW    : default byte width
//   TIMEOUT_BITS  : stall-timeout counter width, same as the UART timer
//   MAX_NREQ      : largest supported requester count
//   onehot_to_idx : index of the set bit in a one-hot vector (0 when empty)
package uart_arb_pkg;

    localparam int unsigned DEFAULT_DW   = 8;
    localparam int unsigned TIMEOUT_BITS = 32;
    localparam int unsigned MAX_NREQ     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // OR of the indices of set bits; exact for one-hot or all-zero input.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
//   i_req_valid/i_req_data/i_req_last/o_req_ready : per-requester byte stream
//   o_grant                                       : one-hot current owner
//   o_tx_valid/o_tx_data/i_tx_ready               : stream into the UART transmitter
//   o_busy                                        : grant held or output byte pending
//   o_timeout                                     : stall-revoke pulse, only with
//                                                   UART_TX_ARBITER_TIMEOUT_EN
// Modports: slave = arbiter side, master = requester/transmitter side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = DEFAULT_DW
);

    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]    i_req_last;
    logic [NREQ-1:0]    o_req_ready;
    logic [NREQ-1:0]    o_grant;
    logic               o_tx_valid;
    logic [DW-1:0]      o_tx_data;
    logic               i_tx_ready;
    logic               o_busy;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic               o_timeout;
`endif

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        output o_timeout,
`endif
        output o_req_ready, o_grant, o_tx_valid, o_tx_data, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        input  o_timeout,
`endif
        input  o_req_ready, o_grant, o_tx_valid, o_tx_data, o_busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   grant_c : one-hot first set request scanning upward from ptr with wrap
//   found_c : at least one request set
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant_c,
    output logic            found_c
);

    logic [PW-1:0] idx;

    // Rotating scan; the first hit wins and blocks the rest.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr) + i) % NREQ);
            if (!found_c && req[idx]) begin
                grant_c[idx] = 1'b1;
                found_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter byte port.
// Ports:
//   clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)    : requester streams, one-hot grant, registered tx stream, busy
// Optional build macro UART_TX_ARBITER_TIMEOUT_EN: revoke a grant whose owner
// has held valid low for TIMEOUT_CYCLES cycles and pulse bus.o_timeout.
// o_req_ready is combinational: it follows i_tx_ready within the cycle so the
// output register can load and drain together at one byte per cycle.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned DW             = DEFAULT_DW,
    parameter int unsigned TIMEOUT_CYCLES = 8680
) (
    input  logic              clk,
    input  logic              i_reset_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned PW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            tx_valid_q, tx_valid_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] pick_grant_c;
    logic            pick_found_c;
    logic            can_load_c;
    logic [NREQ-1:0] req_ready_c;
    logic            xfer_c;
    logic            own_valid_c;
    logic            own_last_c;
    logic [DW-1:0]   own_data_c;
    logic [PW-1:0]   owner_idx_c;
    logic [PW-1:0]   ptr_next_c;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_q, timeout_d;
`else
    // Timeout setting has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_BITS'(TIMEOUT_CYCLES);
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (bus.i_req_valid),
        .ptr     (ptr_q),
        .grant_c (pick_grant_c),
        .found_c (pick_found_c)
    );

    // Owner lane select; grant_q is one-hot or zero.
    always_comb begin
        own_valid_c = 1'b0;
        own_last_c  = 1'b0;
        own_data_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                own_valid_c = bus.i_req_valid[i];
                own_last_c  = bus.i_req_last[i];
                own_data_c  = bus.i_req_data[i*DW +: DW];
            end
        end
    end

    assign owner_idx_c = PW'(onehot_to_idx(MAX_NREQ'(grant_q)));
    assign ptr_next_c  = (32'(owner_idx_c) == NREQ - 1) ? '0 : owner_idx_c + PW'(1);
    assign can_load_c  = !tx_valid_q || bus.i_tx_ready;
    assign req_ready_c = (state_q == LOCK && can_load_c) ? grant_q : '0;
    assign xfer_c      = |(bus.i_req_valid & req_ready_c);

    // Next-state, grant, pointer and output-register update.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = 1'b0;
`endif

        if (tx_valid_q && bus.i_tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (xfer_c) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data_c;
        end

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    state_d = LOCK;
                    grant_d = pick_grant_c;
                end
            end
            LOCK: begin
                if (xfer_c && own_last_c) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next_c;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (xfer_c) begin
                    tmo_cnt_d = '0;
                end else if (!own_valid_c) begin
                    if (tmo_cnt_q == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        ptr_d     = ptr_next_c;
                        tmo_cnt_d = '0;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d == LOCK) || tx_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.o_req_ready = req_ready_c;
    assign bus.o_grant     = grant_q;
    assign bus.o_tx_valid  = tx_valid_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_busy      = busy_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    assign bus.o_timeout   = timeout_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter byte port between NREQ requesters (console echo, status reporter, debug dump, etc.). Arbitration is round-robin and packet-locked: a granted requester keeps the transmitter until it hands over a byte flagged last. The block sits between the requesters and the tx_uart byte input, and drives a registered valid/ready stream into the transmitter.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, byte width
TIMEOUT_CYCLES, 8680, idle cycles before a stalled grant is revoked (used only with the optional feature)

Ports:
clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_req_valid  input  NREQ  per-requester byte valid
i_req_data  input  NREQ*DW  packed bytes; requester k is at [k*DW +: DW]
i_req_last  input  NREQ  byte is the final byte of its packet
o_req_ready  output  NREQ  per-requester accept
o_grant  output  NREQ  one-hot current owner; all zero when idle
o_tx_valid  output  1  byte valid to the transmitter
o_tx_data  output  DW  byte to the transmitter
i_tx_ready  input  1  transmitter can accept a byte (not busy)
o_busy  output  1  grant held or output register occupied

Behaviour:
- Reset (asynchronous, i_reset_n=0): state IDLE; o_grant=0; o_tx_valid=0; o_tx_data=0; o_req_ready=0; o_busy=0; round-robin pointer=0.
- FSM states:
  - IDLE: if any i_req_valid bit is set, pick the first set bit scanning from the pointer upward, with wrap-around. Register o_grant to that one-hot value and move to LOCK. The grant is visible 1 cycle after the request.
  - LOCK: the owner's data is forwarded.
- Output register:
  - Holds one byte.
  - Drained when o_tx_valid && i_tx_ready.
  - Can load when (!o_tx_valid || i_tx_ready); load and drain may happen in the same cycle, giving one byte per cycle at full throughput.
- o_req_ready[g] = (state==LOCK) && owner g && output register can load. Ready is 0 for every non-owner.
- A byte transfers when i_req_valid[g] && o_req_ready[g]. The byte is loaded into the output register and o_tx_valid=1 on the next cycle.
- Transfer with i_req_last=1:
  - Next cycle: state IDLE, o_grant=0, pointer=(g+1) mod NREQ.
  - The output register may still hold that byte; a new arbitration may proceed in parallel.
- In IDLE, no requester is ready. A new owner's first byte can be accepted no earlier than 2 cycles after the previous last byte.
- o_tx_valid and o_tx_data stay stable while o_tx_valid && !i_tx_ready.
- Requests from other requesters during LOCK are ignored until release; there is no preemption.
- A requester dropping valid mid-packet keeps the grant. Without the optional feature it waits indefinitely.
- The pointer advances only on release, which gives fairness: each requester waits at most NREQ-1 packets.
- o_busy = (state==LOCK) || o_tx_valid.

Optional Feature:
Macro: UART_TX_ARBITER_TIMEOUT_EN
- Defined:
  - A TIMEOUT_BITS-wide counter runs while in LOCK with i_req_valid[g]=0; any owner transfer reloads it.
  - On reaching TIMEOUT_CYCLES: release to IDLE, advance the pointer, and pulse extra output o_timeout (1 bit, 1 cycle).
  - A pending output byte is still delivered.
- Undefined: no counter, no o_timeout port, and the grant is held until a last byte.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (IDLE, LOCK);
  - the default DW=8;
  - the TIMEOUT_BITS constant (32, matching the UART timer width).
- One sub-module, rr_pick: combinational round-robin picker taking (req vector, pointer) and producing a one-hot grant plus a found flag.

Test Plan:
- Reset: i_reset_n low mid-packet (owner 1, byte 2 of 3 pending) -> next edge o_grant=0, o_tx_valid=0, o_req_ready=0; after release, a request from 1 gives grant 0b0010 one cycle later.
- Single packet: req0 sends 0x48,0x69(last) with i_tx_ready=1 -> o_tx_data 0x48 then 0x69 on consecutive cycles; o_grant=0 on the cycle after the last transfer.
- Contention: req0, req2, req3 all valid with 1-byte packets, pointer=0 -> grant order 0, 2, 3, then 0 again when re-requested.
- Back-pressure: i_tx_ready=0 for 20 cycles with a byte 0xA5 held -> o_tx_valid=1 and o_tx_data=0xA5 stable; o_req_ready[g]=0; exactly one transfer when ready rises.
- Locking: owner 1 stalls valid for 100 cycles while req2 is valid -> o_grant stays 0b0010 and o_req_ready[2]=0 throughout.
- With UART_TX_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16: owner stalls -> o_timeout pulses once after 16 idle cycles, then the grant passes to req2.
